// File: rtl/cpu_8bit_pkg.sv
// Shared definitions for the byte-serial 8-bit-bus CPU: opcode set,
// general-register indices, FSM states and completion codes.
package cpu_8bit_pkg;

    // Full opcode set of the instruction format; only a subset is executed,
    // every other code behaves as NOP.
    typedef enum logic [4:0] {
        OP_NOP   = 5'b00000,
        OP_HALT  = 5'b00001,
        OP_LOAD  = 5'b00010,
        OP_STORE = 5'b00011,
        OP_SLL   = 5'b00100,
        OP_SLA   = 5'b00101,
        OP_SRL   = 5'b00110,
        OP_SRA   = 5'b00111,
        OP_ADD   = 5'b01000,
        OP_ADDI  = 5'b01001,
        OP_SUB   = 5'b01010,
        OP_SUBI  = 5'b01011,
        OP_CMP   = 5'b01100,
        OP_AND   = 5'b01101,
        OP_OR    = 5'b01110,
        OP_XOR   = 5'b01111,
        OP_LDIH  = 5'b10000,
        OP_ADDC  = 5'b10001,
        OP_SUBC  = 5'b10010,
        OP_SET   = 5'b10011,
        OP_JUMP  = 5'b11000,
        OP_JMPR  = 5'b11001,
        OP_BZ    = 5'b11010,
        OP_BNZ   = 5'b11011,
        OP_BN    = 5'b11100,
        OP_BNN   = 5'b11101,
        OP_BC    = 5'b11110,
        OP_BNC   = 5'b11111
    } opcode_e;

    localparam logic [2:0] GR0 = 3'd0;
    localparam logic [2:0] GR1 = 3'd1;
    localparam logic [2:0] GR2 = 3'd2;
    localparam logic [2:0] GR3 = 3'd3;
    localparam logic [2:0] GR4 = 3'd4;
    localparam logic [2:0] GR5 = 3'd5;
    localparam logic [2:0] GR6 = 3'd6;
    localparam logic [2:0] GR7 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_EX   = 3'd3,
        ST_M0   = 3'd4,
        ST_M1   = 3'd5
    } state_e;

    // Values reported on nxt when the CPU returns to IDLE.
    localparam logic [1:0] NXT_NONE   = 2'b00;
    localparam logic [1:0] NXT_HALT   = 2'b01;
    localparam logic [1:0] NXT_RELOAD = 2'b10;

    function automatic logic is_mem_state(state_e s);
        return (s == ST_M0) || (s == ST_M1);
    endfunction

endpackage

// File: rtl/cpu_8bit_alu.sv
// 16-bit adder/subtractor shared by ADD and SUBI; reports a zero result.
module cpu_8bit_alu (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] result,
    output logic        zero
);

    // Wrap-around add or subtract, zero flag from the 16-bit result.
    always_comb begin
        result = sub ? (a - b) : (a + b);
        zero   = (result == 16'h0000);
    end

endmodule

// File: rtl/i_memory_8bit.sv
// 512 x 8 unified instruction/data RAM: combinational read, clocked write.
// Contents survive reset so a host-loaded program is not lost.
module i_memory_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] addr,
    input  logic       d_we,
    input  logic [7:0] datain,
    output logic [7:0] dataout
);

    logic [7:0] I_RAM [0:511];

    assign dataout = I_RAM[addr];

    // Byte write; writes are suppressed while reset is held so an aborted
    // STORE cannot land a byte during reset.
    always_ff @(posedge clk) begin
        if (d_we && rst_n) begin
            I_RAM[addr] <= datain;
        end
    end

endmodule

// File: rtl/serial_cpu_8bit.sv
// Multi-cycle CPU with 16-bit instructions over an 8-bit memory bus.
// Each instruction is fetched as two bytes (F0/F1), executed in EX, and
// LOAD/STORE move their data word as two bytes in M0/M1.
module serial_cpu_8bit
    import cpu_8bit_pkg::*;
#(
    parameter logic [7:0] DEFAULT_PC_ADDR = 8'd250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] i_datain,
    input  logic [7:0] d_datain,
    output logic       is_i_addr,
    output logic [1:0] nxt,
    output logic [8:0] i_addr,
    output logic [8:0] d_addr,
    output logic       d_we,
    output logic [7:0] d_dataout
);

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] gr_q [8];
    logic [15:0] gr_d [8];
    logic        z_q, z_d;
    logic [7:0]  ir_lo_q, ir_lo_d;
    logic [7:0]  ir_hi_q, ir_hi_d;
    logic [7:0]  mdr_lo_q, mdr_lo_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [1:0]  nxt_q, nxt_d;
    logic        is_i_addr_q, is_i_addr_d;
    logic [8:0]  i_addr_q, i_addr_d;
    logic [8:0]  d_addr_q, d_addr_d;
    logic        d_we_q, d_we_d;
    logic [7:0]  d_dataout_q, d_dataout_d;

    // Instruction fields, valid from EX until the next fetch overwrites them.
    logic [15:0] instr;
    opcode_e     op;
    logic [2:0]  rd, r1, r2, rb;
    logic [7:0]  imm8;
    logic [3:0]  uimm4;

    assign instr = {ir_hi_q, ir_lo_q};
    assign op    = opcode_e'(instr[15:11]);
    assign rd    = instr[10:8];
    assign r1    = instr[6:4];
    assign r2    = instr[2:0];
    assign rb    = instr[6:4];
    assign imm8  = instr[7:0];
    assign uimm4 = instr[3:0];

    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_sub, alu_zero;

    assign alu_sub = (op == OP_SUBI);
    assign alu_a   = alu_sub ? gr_q[rd] : gr_q[r1];
    assign alu_b   = alu_sub ? {8'h00, imm8} : gr_q[r2];

    cpu_8bit_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .sub    (alu_sub),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Next-state, datapath and next-output computation for the whole CPU.
    always_comb begin
        // NOTE: every variable gets a hold value first so no path through the
        // case statements leaves one unassigned and infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        gr_d     = gr_q;
        z_d      = z_q;
        ir_lo_d  = ir_lo_q;
        ir_hi_d  = ir_hi_q;
        mdr_lo_d = mdr_lo_q;
        waddr_d  = waddr_q;
        nxt_d    = nxt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_F0;
                    nxt_d   = NXT_NONE;
                end
            end
            ST_F0: begin
                ir_lo_d = i_datain;
                state_d = ST_F1;
            end
            ST_F1: begin
                ir_hi_d = i_datain;
                state_d = ST_EX;
            end
            ST_EX: begin
                state_d = ST_F0;
                pc_d    = pc_q + 8'd1;
                case (op)
                    OP_SET: gr_d[rd] = {8'h00, imm8};
                    OP_ADD, OP_SUBI: begin
                        gr_d[rd] = alu_result;
                        z_d      = alu_zero;
                    end
                    OP_LOAD, OP_STORE: begin
                        waddr_d = gr_q[rb][7:0] + {4'h0, uimm4};
                        state_d = ST_M0;
                    end
                    OP_BNZ: begin
                        if (!z_q) begin
                            pc_d = pc_q + 8'd2 + imm8;
                        end
                    end
                    OP_JMPR: begin
                        pc_d    = gr_q[rd][7:0] + imm8;
                        state_d = ST_IDLE;
                        nxt_d   = NXT_RELOAD;
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_IDLE;
                        nxt_d   = NXT_HALT;
                    end
                    default: ;
                endcase
            end
            ST_M0: begin
                mdr_lo_d = d_datain;
                state_d  = ST_M1;
            end
            ST_M1: begin
                if (op == OP_LOAD) begin
                    gr_d[rd] = {d_datain, mdr_lo_q};
                end
                state_d = ST_F0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state
        // being entered rather than the current one.
        is_i_addr_d = !is_mem_state(state_d);
        i_addr_d    = {pc_d, state_d == ST_F1};
        d_addr_d    = d_addr_q;
        d_we_d      = 1'b0;
        d_dataout_d = d_dataout_q;
        if (is_mem_state(state_d)) begin
            d_addr_d = {waddr_d, state_d == ST_M1};
            if (op == OP_STORE) begin
                d_we_d      = 1'b1;
                d_dataout_d = (state_d == ST_M1) ? gr_q[rd][15:8] : gr_q[rd][7:0];
            end
        end
    end

    // State and registered outputs; everything holds while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= DEFAULT_PC_ADDR;
            // NOTE: the register file is a handful of flops and is cleared
            // here; the RAM is a true memory and is deliberately never reset.
            for (int i = 0; i < 8; i++) begin
                gr_q[i] <= 16'h0000;
            end
            z_q         <= 1'b0;
            ir_lo_q     <= 8'h00;
            ir_hi_q     <= 8'h00;
            mdr_lo_q    <= 8'h00;
            waddr_q     <= 8'h00;
            nxt_q       <= NXT_NONE;
            is_i_addr_q <= 1'b1;
            i_addr_q    <= {DEFAULT_PC_ADDR, 1'b0};
            d_addr_q    <= 9'h000;
            d_we_q      <= 1'b0;
            d_dataout_q <= 8'h00;
        end else if (enable) begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            pc_q        <= pc_d;
            gr_q        <= gr_d;
            z_q         <= z_d;
            ir_lo_q     <= ir_lo_d;
            ir_hi_q     <= ir_hi_d;
            mdr_lo_q    <= mdr_lo_d;
            waddr_q     <= waddr_d;
            nxt_q       <= nxt_d;
            is_i_addr_q <= is_i_addr_d;
            i_addr_q    <= i_addr_d;
            d_addr_q    <= d_addr_d;
            d_we_q      <= d_we_d;
            d_dataout_q <= d_dataout_d;
        end
    end

    assign is_i_addr = is_i_addr_q;
    assign nxt       = nxt_q;
    assign i_addr    = i_addr_q;
    assign d_addr    = d_addr_q;
    assign d_we      = d_we_q;
    assign d_dataout = d_dataout_q;

endmodule

// File: tb/tb_serial_cpu_8bit.sv
// Bench for serial_cpu_8bit paired with i_memory_8bit: directed programs
// with hand-derived results, then random programs against an
// instruction-level reference model.
module tb_serial_cpu_8bit;
    import cpu_8bit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, enable, start;
    logic [7:0] i_datain, d_datain, d_dataout, mem_dout;
    logic       is_i_addr, d_we;
    logic [1:0] nxt;
    logic [8:0] i_addr, d_addr;

    // Host port into the RAM, used only while the CPU is idle.
    logic       tb_mode, tb_we;
    logic [8:0] tb_addr;
    logic [7:0] tb_wdata;
    logic [8:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_din;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [7:0]  ref_mem [512];
    logic [7:0]  m_pc;
    logic [15:0] m_gr [8];
    logic        m_z;
    logic [1:0]  m_nxt;
    int          m_cycles;

    always #5 clk = ~clk;

    assign mem_addr = tb_mode ? tb_addr  : (is_i_addr ? i_addr : d_addr);
    assign mem_we   = tb_mode ? tb_we    : d_we;
    assign mem_din  = tb_mode ? tb_wdata : d_dataout;
    assign i_datain = mem_dout;
    assign d_datain = mem_dout;

    serial_cpu_8bit #(.DEFAULT_PC_ADDR(8'd250)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .is_i_addr (is_i_addr),
        .nxt       (nxt),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_dataout (d_dataout)
    );

    i_memory_8bit u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (mem_addr),
        .d_we    (mem_we),
        .datain  (mem_din),
        .dataout (mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] i_imm(logic [4:0] op, logic [2:0] rd, logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [15:0] i_rr(logic [4:0] op, logic [2:0] rd, logic [2:0] r1, logic [2:0] r2);
        return {op, rd, 1'b0, r1, 1'b0, r2};
    endfunction

    function automatic logic [15:0] i_mem(logic [4:0] op, logic [2:0] rd, logic [2:0] rb, logic [3:0] u4);
        return {op, rd, 1'b0, rb, u4};
    endfunction

    task automatic wr_word(input logic [7:0] w, input logic [15:0] v);
        ref_mem[{w, 1'b0}] = v[7:0];
        ref_mem[{w, 1'b1}] = v[15:8];
        @(negedge clk);
        tb_mode = 1'b1; tb_we = 1'b1; tb_addr = {w, 1'b0}; tb_wdata = v[7:0];
        @(negedge clk);
        tb_addr = {w, 1'b1}; tb_wdata = v[15:8];
        @(negedge clk);
        tb_we = 1'b0; tb_mode = 1'b0;
    endtask

    task automatic rd_word(input logic [7:0] w, output logic [15:0] v);
        tb_mode = 1'b1; tb_we = 1'b0; tb_addr = {w, 1'b0};
        #1 v[7:0] = mem_dout;
        tb_addr = {w, 1'b1};
        #1 v[15:8] = mem_dout;
        tb_mode = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [7:0] w, input logic [15:0] exp);
        logic [15:0] v;
        @(negedge clk);
        rd_word(w, v);
        check(tag, v, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Starts the CPU and counts clock edges until it reports completion.
    // Optionally drops enable for hold_len edges once hold_at edges have passed.
    task automatic run_cpu(input int max_cycles, input int hold_at, input int hold_len, output int cycles);
        logic [29:0] snap;
        pulse_start();
        cycles = 0;
        while (nxt == 2'b00 && cycles < max_cycles) begin
            @(posedge clk);
            #1 cycles++;
            if (cycles == hold_at) begin
                enable = 1'b0;
                snap = {is_i_addr, i_addr, d_addr, d_we, d_dataout, nxt};
                repeat (hold_len) @(posedge clk);
                #1;
                check("hold_outputs", {is_i_addr, i_addr, d_addr, d_we, d_dataout, nxt}, snap);
                // The hold lands on the first data cycle of the loop's STORE.
                check("hold_d_we", d_we, 1'b1);
                check("hold_d_addr", d_addr, 9'd4);
                check("hold_d_dataout", d_dataout, 8'h0A);
                check("hold_is_i_addr", is_i_addr, 1'b0);
                enable = 1'b1;
            end
        end
        check("run_completed", nxt != 2'b00, 1'b1);
    endtask

    // Instruction-level model: executes from m_pc until HALT or JMPR.
    task automatic ref_run();
        logic [15:0] ins;
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [7:0]  imm, w;
        int          t, v;
        m_nxt = 2'b00;
        m_cycles = 0;
        for (int step = 0; step < 256 && m_nxt == 2'b00; step++) begin
            ins = {ref_mem[{m_pc, 1'b1}], ref_mem[{m_pc, 1'b0}]};
            op  = ins[15:11];
            rd  = ins[10:8];
            imm = ins[7:0];
            w   = 8'((int'(m_gr[ins[6:4]][7:0]) + int'(ins[3:0])) % 256);
            m_cycles += 3;
            t = int'(m_pc) + 1;
            case (op)
                OP_HALT: begin t = int'(m_pc); m_nxt = 2'b01; end
                OP_JMPR: begin t = int'(m_gr[rd][7:0]) + int'($signed(imm)); m_nxt = 2'b10; end
                OP_SET:  m_gr[rd] = {8'h00, imm};
                OP_ADD: begin
                    v = (int'(m_gr[ins[6:4]]) + int'(m_gr[ins[2:0]])) % 65536;
                    m_gr[rd] = 16'(v);
                    m_z = (v == 0);
                end
                OP_SUBI: begin
                    v = (int'(m_gr[rd]) - int'(imm) + 65536) % 65536;
                    m_gr[rd] = 16'(v);
                    m_z = (v == 0);
                end
                OP_BNZ: if (!m_z) t = int'(m_pc) + 2 + int'($signed(imm));
                OP_LOAD: begin
                    m_cycles += 2;
                    m_gr[rd] = {ref_mem[{w, 1'b1}], ref_mem[{w, 1'b0}]};
                end
                OP_STORE: begin
                    m_cycles += 2;
                    ref_mem[{w, 1'b0}] = m_gr[rd][7:0];
                    ref_mem[{w, 1'b1}] = m_gr[rd][15:8];
                end
                default: ;
            endcase
            m_pc = 8'(((t % 256) + 256) % 256);
        end
    endtask

    task automatic load_loop();
        wr_word(8'd250, i_imm(OP_SET, GR3, 8'd4));
        wr_word(8'd251, i_imm(OP_SET, GR1, 8'd0));
        wr_word(8'd252, i_rr(OP_ADD, GR1, GR1, GR3));
        wr_word(8'd253, i_imm(OP_SUBI, GR3, 8'd1));
        wr_word(8'd254, i_imm(OP_BNZ, GR0, 8'hFC));
        wr_word(8'd255, i_mem(OP_STORE, GR1, GR0, 4'd2));
        wr_word(8'd0,   i_imm(OP_JMPR, GR0, 8'hFA));
        wr_word(8'd1,   16'h3C00);
        wr_word(8'd2,   16'h0000);
    endtask

    initial begin
        int          cyc, len, sel;
        logic [15:0] ins, v;
        logic [2:0]  rd;
        logic [3:0]  u4;

        rst_n = 1'b0; enable = 1'b1; start = 1'b0;
        tb_mode = 1'b0; tb_we = 1'b0; tb_addr = 9'h000; tb_wdata = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values of every output.
        check("rst_nxt", nxt, 2'b00);
        check("rst_is_i_addr", is_i_addr, 1'b1);
        check("rst_i_addr", i_addr, {8'd250, 1'b0});
        check("rst_d_addr", d_addr, 9'h000);
        check("rst_d_we", d_we, 1'b0);
        check("rst_d_dataout", d_dataout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Summing loop ending in JMPR back to 250.
        load_loop();
        run_cpu(100, -1, 0, cyc);
        check("loop_nxt", nxt, 2'b10);
        check("loop_pc", i_addr, {8'd250, 1'b0});
        check("loop_cycles", cyc, 50);
        check_word("loop_word2", 8'd2, 16'h000A);
        check_word("loop_word1", 8'd1, 16'h3C00);

        // Reload and restart; registers carry over from the previous run.
        wr_word(8'd250, i_mem(OP_LOAD, GR2, GR0, 4'd1));
        wr_word(8'd251, i_rr(OP_ADD, GR1, GR1, GR2));
        wr_word(8'd252, i_mem(OP_STORE, GR1, GR0, 4'd3));
        wr_word(8'd253, i_imm(OP_HALT, GR0, 8'd0));
        wr_word(8'd3, 16'h0000);
        run_cpu(100, -1, 0, cyc);
        check("reload_nxt", nxt, 2'b01);
        check("reload_pc", i_addr, {8'd253, 1'b0});
        check("reload_cycles", cyc, 16);
        check_word("reload_word3", 8'd3, 16'h3C0A);
        check_word("reload_word1", 8'd1, 16'h3C00);

        // Restart from the old HALT location into a long loop, then reset mid-run.
        load_loop();
        wr_word(8'd12, 16'hABCD);
        wr_word(8'd13, 16'hABCD);
        wr_word(8'd14, 16'hABCD);
        pulse_start();
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_nxt", nxt, 2'b00);
        check("midrst_i_addr", i_addr, {8'd250, 1'b0});
        check("midrst_is_i_addr", is_i_addr, 1'b1);
        check("midrst_d_we", d_we, 1'b0);
        check("midrst_d_addr", d_addr, 9'h000);
        check("midrst_d_dataout", d_dataout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        check_word("midrst_ram250", 8'd250, i_imm(OP_SET, GR3, 8'd4));
        check_word("midrst_ram254", 8'd254, i_imm(OP_BNZ, GR0, 8'hFC));
        wr_word(8'd250, i_mem(OP_STORE, GR1, GR0, 4'd12));
        wr_word(8'd251, i_mem(OP_STORE, GR2, GR0, 4'd13));
        wr_word(8'd252, i_mem(OP_STORE, GR3, GR0, 4'd14));
        wr_word(8'd253, i_imm(OP_HALT, GR0, 8'd0));
        run_cpu(100, -1, 0, cyc);
        check("midrst_run_nxt", nxt, 2'b01);
        check("midrst_run_cycles", cyc, 18);
        check_word("midrst_gr1", 8'd12, 16'h0000);
        check_word("midrst_gr2", 8'd13, 16'h0000);
        check_word("midrst_gr3", 8'd14, 16'h0000);

        // Same loop with enable dropped during the STORE; result unchanged.
        do_reset();
        load_loop();
        run_cpu(100, 45, 6, cyc);
        check("hold_nxt", nxt, 2'b10);
        check("hold_cycles", cyc, 50);
        check("hold_pc", i_addr, {8'd250, 1'b0});
        check_word("hold_word2", 8'd2, 16'h000A);

        // 0xFFFF + 1 wraps to 0 and sets Z, so BNZ falls through to the stores.
        wr_word(8'd8, 16'h5555);
        wr_word(8'd9, 16'h5555);
        wr_word(8'd250, i_imm(OP_SET, GR1, 8'd0));
        wr_word(8'd251, i_imm(OP_SUBI, GR1, 8'd1));
        wr_word(8'd252, i_imm(OP_SET, GR2, 8'd1));
        wr_word(8'd253, i_rr(OP_ADD, GR3, GR1, GR2));
        wr_word(8'd254, i_imm(OP_BNZ, GR0, 8'h01));
        wr_word(8'd255, i_mem(OP_STORE, GR1, GR0, 4'd8));
        wr_word(8'd0,   i_mem(OP_STORE, GR3, GR0, 4'd9));
        wr_word(8'd1,   i_imm(OP_HALT, GR0, 8'd0));
        run_cpu(100, -1, 0, cyc);
        check("ovf_nxt", nxt, 2'b01);
        check("ovf_pc", i_addr, {8'd1, 1'b0});
        check("ovf_cycles", cyc, 28);
        check_word("ovf_word8", 8'd8, 16'hFFFF);
        check_word("ovf_word9", 8'd9, 16'h0000);

        // Random programs at 250 with data in words 8..15, checked against the model.
        for (int it = 0; it < 20; it++) begin
            do_reset();
            m_pc = 8'd250;
            m_z = 1'b0;
            for (int r = 0; r < 8; r++) m_gr[r] = 16'h0000;
            for (int w = 8; w < 16; w++) wr_word(8'(w), 16'($urandom));
            len = $urandom_range(4, 13);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 7);
                rd  = 3'($urandom_range(1, 7));
                u4  = 4'($urandom_range(8, 15));
                case (sel)
                    0: ins = i_imm(OP_SET, rd, 8'($urandom_range(0, 5)));
                    1: ins = i_rr(OP_ADD, rd, 3'($urandom), 3'($urandom));
                    2: ins = i_imm(OP_SUBI, rd, 8'($urandom_range(0, 3)));
                    3: ins = i_mem(OP_LOAD, rd, GR0, u4);
                    4: ins = i_mem(OP_STORE, 3'($urandom), GR0, u4);
                    5: ins = (i == len - 1) ? i_imm(OP_NOP, GR0, 8'd0) : i_imm(OP_BNZ, GR0, 8'd0);
                    6: ins = i_rr(OP_XOR, rd, 3'($urandom), 3'($urandom));
                    default: ins = i_imm(OP_SET, rd, 8'($urandom));
                endcase
                wr_word(8'(250 + i), ins);
            end
            wr_word(8'(250 + len), i_imm(OP_HALT, GR0, 8'd0));
            ref_run();
            run_cpu(400, -1, 0, cyc);
            check("rand_nxt", nxt, m_nxt);
            check("rand_pc", i_addr, {m_pc, 1'b0});
            check("rand_cycles", cyc, m_cycles);
            for (int w = 8; w < 16; w++) begin
                @(negedge clk);
                rd_word(8'(w), v);
                check("rand_word", v, {ref_mem[9'(2 * w + 1)], ref_mem[9'(2 * w)]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
